bus_op_sequencer: RTL
=====================

Name: bus_op_sequencer

Overview:
Controller that shares the 8-bit ALU/shifter bus datapath (device+operation code, operand registers A/B, result C) between two requesters. It arbitrates round-robin and latches one command with its operands. It then sequences the datapath's operand-load steps and execution, and returns the result through a per-requester valid/ready response. It sits between the two requesting masters and the single datapath instance.

Parameters:
DATA_W, 8, operand/result width
CNT_W, 16, width of completed-transaction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  2  request valid, bit i = requester i
req_ready  out  2  request accepted (combinational, IDLE only)
req_cmd0  in  4  requester 0 code {dispositivo[1:0], operacion[1:0]}
req_a0  in  DATA_W  requester 0 operand A
req_b0  in  DATA_W  requester 0 operand B
req_cmd1  in  4  requester 1 code
req_a1  in  DATA_W  requester 1 operand A
req_b1  in  DATA_W  requester 1 operand B
rsp_valid  out  2  response valid, one-hot to owning requester
rsp_ready  in  2  response consumed
rsp_data  out  DATA_W  result
rsp_err  out  1  illegal code flag
dp_codigo  out  4  code driven to datapath
dp_data  out  DATA_W  operand bus to datapath
dp_load_a  out  1  datapath loads A from dp_data
dp_load_b  out  1  datapath loads B from dp_data
dp_c  in  DATA_W  datapath result (combinational from code, A, B)
busy  out  1  high in any state except IDLE
op_count  out  CNT_W  completed legal transactions

Behaviour:
- Only one clock domain; all state changes on posedge clk.
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, dp_codigo 0, dp_data 0, dp_load_a/b 0, busy 0, op_count 0, RR pointer favours requester 0.
- Legal codes and operand needs:
  - 0000 C=A (A only)
  - 0001 C=A+B (A, B)
  - 0010 C=B (B only)
  - 0011 C=A-B (A, B)
  - 0100 C=A<<1 (A only)
  - 1000 C=B<<1 (B only)
  - All other codes are illegal.
- Arithmetic is mod 2^DATA_W. Subtraction wraps. A shift drops the MSB and inserts LSB 0. The sequencer does no arithmetic itself; it captures dp_c.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, RESP.
- IDLE: req_ready is one-hot to the arbitration winner when any req_valid=1. The handshake is req_valid&req_ready in the same cycle (T); it latches cmd/A/B and the owner id, and updates the RR pointer to the non-owner.
- Transitions from IDLE:
  - illegal code -> RESP
  - needs A -> LOAD_A
  - B only -> LOAD_B
- LOAD_A: dp_data=A, dp_load_a=1 for exactly 1 cycle. Goes to LOAD_B if B is needed, else EXEC.
- LOAD_B: dp_data=B, dp_load_b=1 for exactly 1 cycle. Goes to EXEC.
- EXEC: dp_codigo stable, capture dp_c into rsp_data, op_count+1 (wraps). Goes to RESP.
- dp_codigo = latched code from the cycle after the handshake until the next handshake. For illegal codes the datapath is untouched, dp_codigo is not updated, and there are no load strobes.
- RESP: rsp_valid[owner]=1, holding rsp_data/rsp_err stable until rsp_ready[owner]. Then IDLE. rsp_ready of the non-owner is ignored.
- Latency (handshake cycle T to first rsp_valid cycle):
  - two-operand: T+4
  - single-operand: T+3
  - illegal: T+1, with rsp_err=1 and rsp_data=0
- Arbitration: with both requesters valid in IDLE, the pointer owner wins. With one valid, it wins regardless of pointer. No new grant is given while busy. A requester may drop req_valid before grant with no effect.
- Back-to-back: IDLE is always visited for at least 1 cycle between transactions, so max throughput is one two-operand op per 5 cycles.
- Reset mid-operation: abort immediately to reset values. No response is issued and the in-flight command is lost. Datapath A/B contents are not cleared by this block.

Decomposition:
- Package bus_ops_pkg holds:
  - state enum
  - codigo localparams (CODE_PASS_A, CODE_ADD, CODE_PASS_B, CODE_SUB, CODE_SHL_A, CODE_SHL_B)
  - functions needs_a(code), needs_b(code), is_legal(code)
- Sub-module rr_arbiter2: 2-way round-robin grant. Inputs are req[1:0] and an advance strobe; output is grant one-hot; pointer reset to requester 0.

Test Plan:
- Reset, then req0 cmd 0001, A=8'd200, B=8'd100 -> load_a at T+1, load_b at T+2, rsp_valid[0] at T+4, rsp_data=8'd44, err=0, op_count=1.
- req1 cmd 0011, A=8'd5, B=8'd9 -> rsp_data=8'd252. req1 cmd 1000, B=8'h81 -> no load_a, rsp_data=8'h02 at T+3.
- Both valid from reset with cmds 0000/0010 -> req0 granted first, req1 second. Repeat with both held -> grants alternate 0,1,0,1.
- req0 cmd 0110 -> rsp_valid[0] at T+1, rsp_err=1, rsp_data=0, no dp_load strobes, op_count unchanged.
- Hold rsp_ready[0]=0 for 10 cycles -> rsp_valid/rsp_data stable, req_ready stays 0 for the pending req1. Assert rsp_ready[1] only -> no effect.
- Assert rst during LOAD_B -> next cycle IDLE, busy=0, rsp_valid=0, no response delivered, op_count=0.

Source files
------------

// File: rtl/bus_op_sequencer_pkg.sv
// Shared types and operation-code helpers for the bus operation sequencer.
// The codes and their operand needs are fixed by the ALU/shifter datapath.
package bus_ops_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [3:0] CODE_PASS_A = 4'b0000;
  localparam logic [3:0] CODE_ADD    = 4'b0001;
  localparam logic [3:0] CODE_PASS_B = 4'b0010;
  localparam logic [3:0] CODE_SUB    = 4'b0011;
  localparam logic [3:0] CODE_SHL_A  = 4'b0100;
  localparam logic [3:0] CODE_SHL_B  = 4'b1000;

  function automatic logic needs_a(input logic [3:0] code);
    return (code == CODE_PASS_A) || (code == CODE_ADD) ||
           (code == CODE_SUB)    || (code == CODE_SHL_A);
  endfunction

  function automatic logic needs_b(input logic [3:0] code);
    return (code == CODE_ADD)  || (code == CODE_PASS_B) ||
           (code == CODE_SUB)  || (code == CODE_SHL_B);
  endfunction

  // Every legal code reads at least one operand.
  function automatic logic is_legal(input logic [3:0] code);
    return needs_a(code) || needs_b(code);
  endfunction

endpackage

// File: rtl/bus_op_sequencer_if.sv
// Request/response handshakes and datapath bus shared by the sequencer.
// slave = the sequencer's view, master = the requesters + datapath side.
interface bus_op_sequencer_if #(parameter int DATA_W = 8);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [3:0]        req_cmd0;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_b0;
  logic [3:0]        req_cmd1;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [3:0]        dp_codigo;
  logic [DATA_W-1:0] dp_data;
  logic              dp_load_a;
  logic              dp_load_b;
  logic [DATA_W-1:0] dp_c;

  modport slave (
    input  req_valid, req_cmd0, req_a0, req_b0, req_cmd1, req_a1, req_b1,
           rsp_ready, dp_c,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           dp_codigo, dp_data, dp_load_a, dp_load_b
  );

  modport master (
    output req_valid, req_cmd0, req_a0, req_b0, req_cmd1, req_a1, req_b1,
           rsp_ready, dp_c,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           dp_codigo, dp_data, dp_load_a, dp_load_b
  );
endinterface

// File: rtl/bus_op_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer names the favoured requester
// and moves to the loser whenever a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);
  logic r_ptr;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = r_ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst)            r_ptr <= 1'b0;
    else if (i_advance) r_ptr <= o_grant[0];
  end
endmodule

// File: rtl/bus_op_sequencer.sv
// Shares one ALU/shifter datapath between two requesters: arbitrate, latch
// a command, strobe operands into the datapath, capture C and respond.
module bus_op_sequencer
  import bus_ops_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  bus_op_sequencer_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  state_t            r_state, w_next;
  logic [1:0]        w_grant, w_hs_vec, w_req_ready, w_rsp_valid;
  logic              w_hs, w_sel;
  logic [3:0]        w_cmd;
  logic [DATA_W-1:0] w_a, w_b, w_dp_data;
  logic              w_load_a, w_load_b;
  logic [3:0]        r_cmd, r_codigo;
  logic [DATA_W-1:0] r_a, r_b, r_rsp_data;
  logic              r_owner, r_rsp_err;
  logic [CNT_W-1:0]  r_op_count;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.req_valid),
    .i_advance (w_hs),
    .o_grant   (w_grant)
  );

  // Grants are only offered while idle and never during reset.
  assign w_req_ready = (r_state == IDLE && !rst) ? w_grant : 2'b00;
  assign w_hs_vec    = bus.req_valid & w_req_ready;
  assign w_hs        = |w_hs_vec;
  assign w_sel       = w_hs_vec[1];
  assign w_cmd       = w_sel ? bus.req_cmd1 : bus.req_cmd0;
  assign w_a         = w_sel ? bus.req_a1   : bus.req_a0;
  assign w_b         = w_sel ? bus.req_b1   : bus.req_b0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_dp_data   = '0;
    w_rsp_valid = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (!is_legal(w_cmd))  w_next = RESP;
          else if (needs_a(w_cmd)) w_next = LOAD_A;
          else                     w_next = LOAD_B;
        end
      end
      LOAD_A: begin
        w_load_a  = 1'b1;
        w_dp_data = r_a;
        w_next    = needs_b(r_cmd) ? LOAD_B : EXEC;
      end
      LOAD_B: begin
        w_load_b  = 1'b1;
        w_dp_data = r_b;
        w_next    = EXEC;
      end
      EXEC: w_next = RESP;
      RESP: begin
        w_rsp_valid = r_owner ? 2'b10 : 2'b01;
        if (bus.rsp_ready[r_owner]) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_owner    <= 1'b0;
      r_codigo   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_hs) begin
        r_cmd   <= w_cmd;
        r_a     <= w_a;
        r_b     <= w_b;
        r_owner <= w_sel;
        // Illegal codes leave the datapath code untouched and answer at once.
        if (is_legal(w_cmd)) begin
          r_codigo  <= w_cmd;
          r_rsp_err <= 1'b0;
        end else begin
          r_rsp_err  <= 1'b1;
          r_rsp_data <= '0;
        end
      end
      if (r_state == EXEC) begin
        r_rsp_data <= bus.dp_c;
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.dp_codigo = r_codigo;
  assign bus.dp_data   = w_dp_data;
  assign bus.dp_load_a = w_load_a;
  assign bus.dp_load_b = w_load_b;
  assign busy          = (r_state != IDLE);
  assign op_count      = r_op_count;
endmodule
